// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, timing constants and
// common device command codes. Used by the transmitter and the receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_tx_state_e;

  // Clock-inhibit length and bus-stall timeout, in 50 MHz system clocks.
  // Simulation builds shrink both so a full transfer stays short.
`ifdef SIMULATION
  localparam int PS2_INHIBIT_CYCLES = 60;
  localparam int PS2_TIMEOUT_CYCLES = 10000;
`else
  localparam int PS2_INHIBIT_CYCLES = 6000;
  localparam int PS2_TIMEOUT_CYCLES = 1000000;
`endif

  // Frequently used host-to-device commands.
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_DISABLE = 8'hF5;

  // PS/2 frames carry odd parity: the parity bit makes the total count of
  // ones across data and parity odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_edge_det.sv
// Two-flop synchronizer for a raw PS/2 pad level plus a one-cycle pulse on
// its falling edge. Shared between the PS/2 transmitter and receiver.
module ps2_edge_det
  import ps2_pkg::*;
(
  input  logic clk_sys,
  input  logic rst_n,
  input  logic line_in,
  output logic line_sync,
  output logic fall_pulse
);

  logic meta;
  logic sync;
  logic prev;

  // Synchronize the pad and keep one cycle of history; the bus idles high
  // so reset to 1 to avoid a phantom edge when reset is released.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= line_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign line_sync  = sync;
  assign fall_pulse = prev & ~sync;

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device command transmitter. Inhibits the bus, issues a
// request-to-send, shifts out data/parity/stop on device clock falling
// edges, checks the device ACK and reports done or error.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       wr_vld,
  input  logic [7:0] wr_data,
  output logic       wr_rdy,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_START = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  ps2_tx_state_e    state;
  logic [7:0]       data_q;
  logic             parity_q;
  logic [3:0]       bit_cnt;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             clk_oe_q;
  logic             data_oe_q;
  logic             done_q;
  logic             err_q;

  logic             clk_sync;
  logic             clk_fall;
  logic [1:0]       data_sync_q;
  logic             data_sync;

  logic [9:0]       frame_bits;
  logic             tx_bit;
  logic             to_expired;

  ps2_edge_det u_clk_edge (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .line_in    (ps2_clk_in),
    .line_sync  (clk_sync),
    .fall_pulse (clk_fall)
  );

  // Data pad gets the same two-flop delay as the clock so both are sampled
  // coherently at the ACK edge and during the idle check.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      data_sync_q <= 2'b11;
    end else begin
      data_sync_q <= {data_sync_q[0], ps2_data_in};
    end
  end

  assign data_sync = data_sync_q[1];

  // Bits after the start bit, in wire order: index n goes out on edge n+1.
  assign frame_bits = {1'b1, parity_q, data_q};
  assign tx_bit     = (bit_cnt <= 4'd9) ? frame_bits[bit_cnt] : 1'b1;
  assign to_expired = (to_cnt == TO_LAST);

  // Transfer sequencer: owns every bus drive and status pulse.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      data_q    <= '0;
      parity_q  <= 1'b0;
      bit_cnt   <= '0;
      inh_cnt   <= '0;
      to_cnt    <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_vld) begin
            data_q    <= wr_data;
            parity_q  <= odd_parity(wr_data);
            bit_cnt   <= '0;
            inh_cnt   <= '0;
            to_cnt    <= '0;
            clk_oe_q  <= 1'b1;
            data_oe_q <= 1'b0;
            state     <= INHIBIT;
          end
        end

        INHIBIT: begin
          if (inh_cnt == INH_LAST) begin
            clk_oe_q <= 1'b0;
            to_cnt   <= '0;
            state    <= REQ;
          end else begin
            inh_cnt <= inh_cnt + INH_W'(1);
            if (inh_cnt == INH_START) begin
              data_oe_q <= 1'b1;
            end
          end
        end

        REQ, SEND: begin
          if (clk_fall) begin
            to_cnt    <= '0;
            data_oe_q <= ~tx_bit;
            bit_cnt   <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd9) begin
              state <= ACK;
            end else begin
              state <= SEND;
            end
          end else if (to_expired) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            err_q     <= 1'b1;
            to_cnt    <= '0;
            state     <= IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        ACK: begin
          if (clk_fall) begin
            to_cnt <= '0;
            if (!data_sync) begin
              state <= WAIT_IDLE;
            end else begin
              err_q <= 1'b1;
              state <= IDLE;
            end
          end else if (to_expired) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            err_q     <= 1'b1;
            to_cnt    <= '0;
            state     <= IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        WAIT_IDLE: begin
          if (clk_sync && data_sync) begin
            done_q <= 1'b1;
            to_cnt <= '0;
            state  <= IDLE;
          end else if (clk_fall) begin
            to_cnt <= '0;
          end else if (to_expired) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            err_q     <= 1'b1;
            to_cnt    <= '0;
            state     <= IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        default: begin
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign wr_rdy      = (state == IDLE);
  assign tx_busy     = ~wr_rdy;
  assign tx_done     = done_q;
  assign tx_err      = err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule
